// File: rtl/alarm_mode_controller_if.sv
// Button/tick/alarm inputs and mode, field-select, strobe and ringer outputs of the mode sequencer.
interface alarm_mode_controller_if;
  logic       tick_1hz;
  logic       btn_c;
  logic       btn_u;
  logic       btn_d;
  logic       btn_l;
  logic       btn_r;
  logic       alarm_match;
  logic [2:0] mode;
  logic [1:0] sel;
  logic       inc_en;
  logic       dec_en;
  logic       clk_run;
  logic       ringing;
  logic       alarm_armed;

  modport master (
    output tick_1hz, btn_c, btn_u, btn_d, btn_l, btn_r, alarm_match,
    input  mode, sel, inc_en, dec_en, clk_run, ringing, alarm_armed
  );

  modport slave (
    input  tick_1hz, btn_c, btn_u, btn_d, btn_l, btn_r, alarm_match,
    output mode, sel, inc_en, dec_en, clk_run, ringing, alarm_armed
  );
endinterface

// File: rtl/alarm_mode_controller.sv
// Alarm clock mode sequencer (run/set/ring, plus snooze when SNOOZE_EN is defined).
// Latency: all outputs registered, one cycle after the sampled pulse.
// Backpressure: none; every pulse is consumed in the cycle it is sampled.
module alarm_mode_controller #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input logic                    clk,
  input logic                    rst,
  alarm_mode_controller_if.slave bus
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_CH = 3'd1,
    SET_CM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4,
`ifdef SNOOZE_EN
    RING   = 3'd5,
    SNOOZE = 3'd6
`else
    RING   = 3'd5
`endif
  } state_t;

  localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam logic [RW-1:0] RING_MAX = RW'(RING_TIMEOUT_SEC);

  state_t        state, nxt;
  logic [1:0]    sel_q, sel_nxt;
  logic          inc_q, dec_q, inc_nxt, dec_nxt;
  logic          clk_run_q, ringing_q;
  logic          armed_q, armed_nxt;
  logic          match_q;
  logic [RW-1:0] ring_cnt, ring_cnt_nxt;
  logic          alarm_rise;
  logic          one_dir;

`ifdef SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam logic [SW-1:0] SNOOZE_MAX = SW'(SNOOZE_SEC);
  logic [SW-1:0] snz_cnt, snz_cnt_nxt;
  logic          any_dir;
  assign any_dir = bus.btn_u | bus.btn_d | bus.btn_l | bus.btn_r;
`endif

  // Edge on the match level so a minute-long match only rings once.
  assign alarm_rise = bus.alarm_match & ~match_q;
  assign one_dir    = bus.btn_u ^ bus.btn_d;

  always_comb begin
    nxt          = state;
    inc_nxt      = 1'b0;
    dec_nxt      = 1'b0;
    armed_nxt    = armed_q;
    ring_cnt_nxt = '0;
`ifdef SNOOZE_EN
    snz_cnt_nxt  = '0;
`endif
    case (state)
      RUN: begin
        if (alarm_rise && armed_q) begin
          nxt = RING;
        end else begin
          if (bus.btn_r) armed_nxt = ~armed_q;
          if (bus.btn_c) nxt = SET_CH;
        end
      end
      SET_CH, SET_CM, SET_AH, SET_AM: begin
        // A strobe takes the cycle so it always lands on the field it was pressed on.
        if (bus.btn_c) begin
          nxt = RUN;
        end else if (one_dir) begin
          inc_nxt = bus.btn_u;
          dec_nxt = bus.btn_d;
        end else if (bus.btn_r) begin
          nxt = (state == SET_AM) ? SET_CH : state_t'(state + 3'd1);
        end else if (bus.btn_l) begin
          nxt = (state == SET_CH) ? SET_AM : state_t'(state - 3'd1);
        end
      end
      RING: begin
        if (bus.btn_c) begin
          nxt = RUN;
`ifdef SNOOZE_EN
        end else if (any_dir) begin
          nxt = SNOOZE;
`endif
        end else if (bus.tick_1hz) begin
          if (ring_cnt + 1'b1 == RING_MAX) nxt = RUN;
          else ring_cnt_nxt = ring_cnt + 1'b1;
        end else begin
          ring_cnt_nxt = ring_cnt;
        end
      end
`ifdef SNOOZE_EN
      SNOOZE: begin
        if (bus.btn_c) begin
          nxt = RUN;
        end else if (bus.tick_1hz) begin
          if (snz_cnt + 1'b1 == SNOOZE_MAX) nxt = RING;
          else snz_cnt_nxt = snz_cnt + 1'b1;
        end else begin
          snz_cnt_nxt = snz_cnt;
        end
      end
`endif
      default: nxt = RUN;
    endcase

    case (nxt)
      SET_CM:  sel_nxt = 2'd1;
      SET_AH:  sel_nxt = 2'd2;
      SET_AM:  sel_nxt = 2'd3;
      default: sel_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      sel_q     <= 2'd0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      clk_run_q <= 1'b1;
      ringing_q <= 1'b0;
      armed_q   <= 1'b0;
      match_q   <= 1'b0;
      ring_cnt  <= '0;
`ifdef SNOOZE_EN
      snz_cnt   <= '0;
`endif
    end else begin
      state     <= nxt;
      sel_q     <= sel_nxt;
      inc_q     <= inc_nxt;
      dec_q     <= dec_nxt;
      clk_run_q <= !(nxt == SET_CH || nxt == SET_CM);
      ringing_q <= (nxt == RING);
      armed_q   <= armed_nxt;
      match_q   <= bus.alarm_match;
      ring_cnt  <= ring_cnt_nxt;
`ifdef SNOOZE_EN
      snz_cnt   <= snz_cnt_nxt;
`endif
    end
  end

  assign bus.mode        = state;
  assign bus.sel         = sel_q;
  assign bus.inc_en      = inc_q;
  assign bus.dec_en      = dec_q;
  assign bus.clk_run     = clk_run_q;
  assign bus.ringing     = ringing_q;
  assign bus.alarm_armed = armed_q;

endmodule
